// File: rtl/shot_manager_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shot_manager_pkg
//  Purpose  : Shared game constants for the gun / score / HUD blocks.
//             It holds the shot-manager state encodings and the default
//             magazine size and cooldown length, so every block that
//             depends on them uses the same values.
//  Revision : 1.0 - initial release
// ============================================================================
package shot_manager_pkg;

    // Default gun configuration.
    localparam int DEFAULT_MAX_SHOTS       = 3;
    localparam int DEFAULT_COOLDOWN_CYCLES = 4;

    // Shot-manager state encodings.
    localparam logic [1:0] S_READY    = 2'd0;
    localparam logic [1:0] S_COOLDOWN = 2'd1;
    localparam logic [1:0] S_ARMWAIT  = 2'd2;
    localparam logic [1:0] S_EMPTY    = 2'd3;

endpackage : shot_manager_pkg
`default_nettype wire

// File: rtl/shot_cooldown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : shot_cooldown_timer
//  Purpose  : Parametrised down-counter. A load pulse sets the count to
//             load_value. The count then drops by one per cycle and stops
//             at zero. A clear pulse forces the count to zero and has
//             priority over load. The block is generic, so other timers
//             such as the duck flight timer can reuse it.
//  Ports    : clk        - system clock
//             reset_n    - asynchronous active-low reset (count -> 0)
//             load       - load load_value on the next edge
//             clear      - force the count to zero on the next edge
//             load_value - value to load, WIDTH bits
//             done       - high while the count is zero
//  Revision : 1.0 - initial release
// ============================================================================
module shot_cooldown_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign done = (r_count == '0);

endmodule : shot_cooldown_timer
`default_nettype wire

// File: rtl/shot_manager.sv
`default_nettype none
// ============================================================================
//  Module   : shot_manager
//  Purpose  : Tracks the remaining shots for one gun. A shot is accepted
//             only in READY, when enable and trigger are high and the
//             magazine is not empty. Each accepted shot produces a
//             one-cycle fire strobe. A cooldown follows each shot, and the
//             trigger must be released before the gun can fire again.
//  Ports    : clk        - system clock
//             reset_n    - asynchronous active-low reset
//             enable     - gameplay active (trigger ignored when low)
//             trigger    - conditioned level trigger
//             reload     - one-cycle pulse that refills the magazine
//             shots_left - remaining shots (registered)
//             fire_pulse - one-cycle strobe per accepted shot (registered)
//             empty      - high when shots_left == 0 (registered)
//             busy       - high when the FSM is not in READY (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module shot_manager
    import shot_manager_pkg::*;
#(
    parameter  int MAX_SHOTS       = DEFAULT_MAX_SHOTS,
    parameter  int COOLDOWN_CYCLES = DEFAULT_COOLDOWN_CYCLES,
    localparam int SHOT_W          = $clog2(MAX_SHOTS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              trigger,
    input  logic              reload,
    output logic [SHOT_W-1:0] shots_left,
    output logic              fire_pulse,
    output logic              empty,
    output logic              busy
);

    localparam int TIMER_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

    localparam logic [SHOT_W-1:0]  C_FULL        = SHOT_W'(MAX_SHOTS);
    localparam logic [TIMER_W-1:0] C_CD_LOAD     =
        TIMER_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
    localparam logic               C_NO_COOLDOWN = (COOLDOWN_CYCLES == 0);

    logic [1:0]        r_state;
    logic [SHOT_W-1:0] r_shots;
    logic              r_fire;
    logic              r_empty;
    logic              r_busy;

    logic [1:0]        w_state_next;
    logic [SHOT_W-1:0] w_shots_next;
    logic              w_fire_next;
    logic              w_tmr_load;
    logic              w_tmr_clear;
    logic              w_tmr_done;

    // The count is loaded with COOLDOWN_CYCLES-1 on the edge that enters
    // COOLDOWN. The FSM leaves on the edge where the count is zero, so it
    // spends exactly COOLDOWN_CYCLES cycles in COOLDOWN.
    shot_cooldown_timer #(
        .WIDTH (TIMER_W)
    ) u_cooldown (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (w_tmr_load),
        .clear      (w_tmr_clear),
        .load_value (C_CD_LOAD),
        .done       (w_tmr_done)
    );

    always_comb begin
        w_state_next = r_state;
        w_shots_next = r_shots;
        w_fire_next  = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_clear  = 1'b0;

        if (reload) begin
            // A reload wins over a shot in the same cycle. The gun re-arms
            // through ARMWAIT, so a trigger held across the reload cannot
            // fire.
            w_shots_next = C_FULL;
            w_state_next = S_ARMWAIT;
            w_tmr_clear  = 1'b1;
        end else begin
            case (r_state)
                S_READY: begin
                    if (r_shots == '0) begin
                        w_state_next = S_EMPTY;
                    end else if (enable && trigger) begin
                        w_shots_next = r_shots - SHOT_W'(1);
                        w_fire_next  = 1'b1;
                        if (C_NO_COOLDOWN) begin
                            w_state_next = S_ARMWAIT;
                        end else begin
                            w_state_next = S_COOLDOWN;
                            w_tmr_load   = 1'b1;
                        end
                    end
                end
                S_COOLDOWN: begin
                    if (w_tmr_done) begin
                        w_state_next = (r_shots == '0) ? S_EMPTY : S_ARMWAIT;
                    end
                end
                S_ARMWAIT: begin
                    if (!trigger) begin
                        w_state_next = (r_shots == '0) ? S_EMPTY : S_READY;
                    end
                end
                S_EMPTY: begin
                    w_state_next = S_EMPTY;
                end
                default: begin
                    w_state_next = S_ARMWAIT;
                end
            endcase
        end
    end

    // All outputs come from the next-state values and are registered here,
    // so they stay glitch-free and line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_ARMWAIT;
            r_shots <= C_FULL;
            r_fire  <= 1'b0;
            r_empty <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_shots <= w_shots_next;
            r_fire  <= w_fire_next;
            r_empty <= (w_shots_next == '0) || (w_state_next == S_EMPTY);
            r_busy  <= (w_state_next != S_READY);
        end
    end

    assign shots_left = r_shots;
    assign fire_pulse = r_fire;
    assign empty      = r_empty;
    assign busy       = r_busy;

endmodule : shot_manager
`default_nettype wire

// File: tb/tb_shot_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shot_manager
//  Purpose  : Directed self-checking bench for shot_manager.
//             Instance A uses the default configuration (3 shots,
//             4-cycle cooldown). Instance B uses 5 shots and no cooldown.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shot_manager;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       trigger;
    logic       reload;
    logic [1:0] shots_left;
    logic       fire_pulse;
    logic       empty;
    logic       busy;

    logic       b_reset_n;
    logic       b_trigger;
    logic       b_reload;
    logic [2:0] b_shots_left;
    logic       b_fire_pulse;
    logic       b_empty;
    logic       b_busy;

    int checks = 0;
    int errors = 0;
    int fires;

    always #5 clk = ~clk;

    shot_manager u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .trigger    (trigger),
        .reload     (reload),
        .shots_left (shots_left),
        .fire_pulse (fire_pulse),
        .empty      (empty),
        .busy       (busy)
    );

    shot_manager #(
        .MAX_SHOTS       (5),
        .COOLDOWN_CYCLES (0)
    ) u_dut_b (
        .clk        (clk),
        .reset_n    (b_reset_n),
        .enable     (enable),
        .trigger    (b_trigger),
        .reload     (b_reload),
        .shots_left (b_shots_left),
        .fire_pulse (b_fire_pulse),
        .empty      (b_empty),
        .busy       (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset A, release it with the trigger low, and land in READY.
    task automatic reset_a();
        trigger = 1'b0;
        reload  = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        enable    = 1'b1;
        trigger   = 1'b0;
        reload    = 1'b0;
        reset_n   = 1'b0;
        b_trigger = 1'b0;
        b_reload  = 1'b0;
        b_reset_n = 1'b0;
        step();
        step();

        // ---- Reset values ----
        check("rst_shots", 32'(shots_left), 32'd3);
        check("rst_fire",  32'(fire_pulse), 32'd0);
        check("rst_empty", 32'(empty),      32'd0);
        check("rst_busy",  32'(busy),       32'd1);

        // ---- 1: single shot, latency, cooldown length ----
        reset_n = 1'b1;
        step();
        check("t1_ready", 32'(busy), 32'd0);
        trigger = 1'b1;
        step();
        check("t1_fire",  32'(fire_pulse), 32'd1);
        check("t1_shots", 32'(shots_left), 32'd2);
        check("t1_busy0", 32'(busy),       32'd1);
        trigger = 1'b0;
        step();
        check("t1_fire_off", 32'(fire_pulse), 32'd0);
        step();
        step();
        step();
        check("t1_busy4", 32'(busy), 32'd1);
        step();
        check("t1_back_ready", 32'(busy), 32'd0);

        // ---- 2: held trigger fires only once ----
        reset_a();
        trigger = 1'b1;
        fires   = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (fire_pulse) fires++;
        end
        check("t2_fires", 32'(fires),      32'd1);
        check("t2_shots", 32'(shots_left), 32'd2);
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        step();
        check("t2_refire",  32'(fire_pulse), 32'd1);
        check("t2_shots_b", 32'(shots_left), 32'd1);

        // ---- 3: drain the magazine, then no underflow ----
        reset_a();
        for (int k = 0; k < 3; k++) begin
            trigger = 1'b1;
            step();
            check("t3_fire",  32'(fire_pulse), 32'd1);
            check("t3_shots", 32'(shots_left), 32'(2 - k));
            trigger = 1'b0;
            for (int j = 0; j < 9; j++) step();
        end
        check("t3_empty", 32'(empty), 32'd1);
        trigger = 1'b1;
        fires   = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (fire_pulse) fires++;
        end
        check("t3_no_fire", 32'(fires),      32'd0);
        check("t3_shots0",  32'(shots_left), 32'd0);
        check("t3_empty_b", 32'(empty),      32'd1);

        // ---- 4: reload from EMPTY with trigger held ----
        reload = 1'b1;
        step();
        reload = 1'b0;
        check("t4_shots", 32'(shots_left), 32'd3);
        check("t4_empty", 32'(empty),      32'd0);
        check("t4_busy",  32'(busy),       32'd1);
        fires = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (fire_pulse) fires++;
        end
        check("t4_no_fire", 32'(fires), 32'd0);
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        step();
        check("t4_fire",    32'(fire_pulse), 32'd1);
        check("t4_shots_b", 32'(shots_left), 32'd2);

        // ---- enable low in READY ----
        reset_a();
        enable  = 1'b0;
        trigger = 1'b1;
        step();
        check("en_no_fire", 32'(fire_pulse), 32'd0);
        check("en_ready",   32'(busy),       32'd0);
        check("en_shots",   32'(shots_left), 32'd3);
        enable  = 1'b1;
        trigger = 1'b0;
        step();

        // ---- 5: reload beats a simultaneous shot ----
        reload  = 1'b1;
        trigger = 1'b1;
        step();
        reload = 1'b0;
        check("t5_no_fire", 32'(fire_pulse), 32'd0);
        check("t5_shots",   32'(shots_left), 32'd3);
        check("t5_armwait", 32'(busy),       32'd1);
        step();
        check("t5_still_no_fire", 32'(fire_pulse), 32'd0);
        trigger = 1'b0;

        // ---- 6: 5 shots, no cooldown, trigger toggled each cycle ----
        b_reset_n = 1'b1;
        step();
        check("t6_ready", 32'(b_busy), 32'd0);
        for (int i = 0; i < 12; i++) begin
            b_trigger = (i % 2 == 0);
            step();
            check("t6_fire", 32'(b_fire_pulse), 32'((i % 2 == 0) && (i <= 8)));
        end
        check("t6_shots0", 32'(b_shots_left), 32'd0);
        check("t6_empty",  32'(b_empty),      32'd1);

        // Asynchronous reset in the middle of a fire pulse.
        b_trigger = 1'b0;
        b_reset_n = 1'b0;
        step();
        b_reset_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            b_trigger = (i % 2 == 0);
            step();
        end
        check("t6_mid_fire",  32'(b_fire_pulse), 32'd1);
        check("t6_mid_shots", 32'(b_shots_left), 32'd3);
        #2;
        b_reset_n = 1'b0;
        #1;
        check("t6_arst_shots", 32'(b_shots_left), 32'd5);
        check("t6_arst_fire",  32'(b_fire_pulse), 32'd0);
        check("t6_arst_busy",  32'(b_busy),       32'd1);
        check("t6_arst_empty", 32'(b_empty),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shot_manager
`default_nettype wire
